// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM controller: FSM encoding,
// byte-select shorthands, idle values of the SRAM strobes and counter sizing.
package dsram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dsram_state_e;

    localparam logic [3:0] SEL_NONE = 4'b1111;
    localparam logic [3:0] SEL_WORD = 4'b0000;

    localparam logic       STROBE_OFF  = 1'b1;
    localparam logic [3:0] BE_OFF      = SEL_NONE;
    localparam logic       DATA_OE_OFF = 1'b0;

    // The counter only ever holds WAIT_CYCLES-1 down to 0.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    endfunction

endpackage

// File: rtl/dsram_wait_cnt.sv
// Loadable down-counter with a zero flag; times the SRAM access phase.
module dsram_wait_cnt #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dsram_ctrl.sv
// Data-SRAM responder: turns a one-cycle MEM-stage request into a timed
// asynchronous-SRAM access. Optional posted stores: DSRAM_POSTED_WRITE_EN.
module dsram_ctrl
    import dsram_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    input  logic [3:0]        mem_sel_i,
    output logic [31:0]       ram_data_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    output logic              sram_data_oe_o,
    input  logic [31:0]       sram_rdata_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o,
    output logic [1:0]        state_o
);

    localparam int               CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    dsram_state_e state;
    logic         is_load_r;
    logic         accept;
    logic         cnt_zero;

    assign accept  = (state == IDLE) && mem_ce_i;
    assign state_o = state;

    dsram_wait_cnt #(.WIDTH(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (CNT_LOAD),
        .dec      (state == ACCESS),
        .zero     (cnt_zero)
    );

`ifdef DSRAM_POSTED_WRITE_EN
    logic posted_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            posted_r <= 1'b0;
        end else if (accept) begin
            posted_r <= !mem_we_i;
        end
    end

    // A store taken in IDLE is acknowledged at once; the DONE cycle of a
    // posted store belongs to nobody, so a waiting request keeps stalling.
    assign stall_o = rst && mem_ce_i && !((state == IDLE) && !mem_we_i)
                     && ((state != DONE) || posted_r);
`else
    assign stall_o = rst && mem_ce_i && (state != DONE);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            is_load_r      <= 1'b1;
            ram_data_o     <= '0;
            sram_addr_o    <= '0;
            sram_wdata_o   <= '0;
            sram_be_n_o    <= BE_OFF;
            sram_ce_n_o    <= STROBE_OFF;
            sram_oe_n_o    <= STROBE_OFF;
            sram_we_n_o    <= STROBE_OFF;
            sram_data_oe_o <= DATA_OE_OFF;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_ce_i) begin
                        state          <= ACCESS;
                        is_load_r      <= mem_we_i;
                        sram_addr_o    <= mem_addr_i[ADDR_W+1:2];
                        sram_be_n_o    <= mem_sel_i;
                        sram_wdata_o   <= mem_data_i;
                        sram_ce_n_o    <= 1'b0;
                        sram_oe_n_o    <= !mem_we_i;
                        sram_we_n_o    <= mem_we_i;
                        sram_data_oe_o <= !mem_we_i;
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        state          <= DONE;
                        sram_ce_n_o    <= STROBE_OFF;
                        sram_oe_n_o    <= STROBE_OFF;
                        sram_we_n_o    <= STROBE_OFF;
                        sram_data_oe_o <= DATA_OE_OFF;
                        if (is_load_r) begin
                            ram_data_o <= sram_rdata_i;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Byte offset and bits above the SRAM address range carry no meaning.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[1:0], mem_addr_i[31:ADDR_W+2]};

endmodule

// File: tb/tb_dsram_ctrl.sv
// Bench for dsram_ctrl: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3,
// each attached to a behavioural asynchronous SRAM.
module tb_dsram_ctrl;
    import dsram_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_ce[2], mem_we[2];
    logic [31:0] mem_addr[2], mem_data[2];
    logic [3:0]  mem_sel[2];
    logic [31:0] ram_data[2];
    logic        stall[2];
    logic [19:0] sram_addr[2];
    logic [31:0] sram_wdata[2];
    logic        data_oe[2];
    logic [31:0] sram_rdata[2];
    logic        ce_n[2], oe_n[2], we_n[2];
    logic [3:0]  be_n[2];
    logic [1:0]  state[2];

    logic [31:0] sram_mem[2][256];
    logic [31:0] exp_q[$];
    int          wc[2] = '{1, 3};
    int          checks = 0;
    int          errors = 0;

    dsram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce[0]), .mem_we_i(mem_we[0]), .mem_addr_i(mem_addr[0]),
        .mem_data_i(mem_data[0]), .mem_sel_i(mem_sel[0]),
        .ram_data_o(ram_data[0]), .stall_o(stall[0]),
        .sram_addr_o(sram_addr[0]), .sram_wdata_o(sram_wdata[0]),
        .sram_data_oe_o(data_oe[0]), .sram_rdata_i(sram_rdata[0]),
        .sram_ce_n_o(ce_n[0]), .sram_oe_n_o(oe_n[0]), .sram_we_n_o(we_n[0]),
        .sram_be_n_o(be_n[0]), .state_o(state[0])
    );

    dsram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce[1]), .mem_we_i(mem_we[1]), .mem_addr_i(mem_addr[1]),
        .mem_data_i(mem_data[1]), .mem_sel_i(mem_sel[1]),
        .ram_data_o(ram_data[1]), .stall_o(stall[1]),
        .sram_addr_o(sram_addr[1]), .sram_wdata_o(sram_wdata[1]),
        .sram_data_oe_o(data_oe[1]), .sram_rdata_i(sram_rdata[1]),
        .sram_ce_n_o(ce_n[1]), .sram_oe_n_o(oe_n[1]), .sram_we_n_o(we_n[1]),
        .sram_be_n_o(be_n[1]), .state_o(state[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural asynchronous SRAM: combinational read, byte-masked write
    assign sram_rdata[0] = sram_mem[0][sram_addr[0][7:0]];
    assign sram_rdata[1] = sram_mem[1][sram_addr[1][7:0]];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!ce_n[k] && !we_n[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (!be_n[k][b]) sram_mem[k][sram_addr[k][7:0]][b*8 +: 8] = sram_wdata[k][b*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One request: drive, count stall cycles, watch the SRAM pins, then
    // compare the returned word against the scoreboard head.
    task automatic do_req(input int k, input bit we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel,
                          input logic [31:0] exp_ram, input int exp_stall, input bit chk_pins);
        int n;
        int acc;
        bit pins_ok;
        @(negedge clk);
        mem_ce[k] = 1'b1; mem_we[k] = we; mem_addr[k] = addr;
        mem_data[k] = data; mem_sel[k] = sel;
        exp_q.push_back(exp_ram);
        #1;
        n = 0; acc = 0; pins_ok = 1'b1;
        while (stall[k] && n < 100) begin
            if (state[k] == 2'(ACCESS)) begin
                acc++;
                if (ce_n[k] !== 1'b0 || oe_n[k] !== ~we || we_n[k] !== we ||
                    data_oe[k] !== ~we || sram_addr[k] !== addr[21:2] ||
                    be_n[k] !== sel || (!we && sram_wdata[k] !== data))
                    pins_ok = 1'b0;
            end
            n++;
            @(negedge clk); #1;
        end
        chk("stall_cycles", n, exp_stall);
        if (chk_pins) begin
            chk("access_cycles", acc, wc[k]);
            chk("access_pins", pins_ok, 1'b1);
            chk("done_state_strobes", {state[k], ce_n[k], oe_n[k], we_n[k], data_oe[k]},
                {2'(DONE), 4'b1110});
        end
        chk("ram_data", ram_data[k], exp_q.pop_front());
    endtask

    typedef struct {
        int          k;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp_ram;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int  n;
        bit  ok;
        int  exp_stall;
        bit  posted;
        logic [31:0] rnd;

`ifdef DSRAM_POSTED_WRITE_EN
        posted = 1'b1;
`else
        posted = 1'b0;
`endif
        tbl[0]  = '{0, 1'b1, 32'h10, 32'h0,        SEL_WORD, 32'hDEADBEEF};
        tbl[1]  = '{0, 1'b0, 32'h24, 32'h000000AB, 4'b1110,  32'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 32'h24, 32'h0,        SEL_WORD, 32'h112233AB};
        tbl[3]  = '{0, 1'b0, 32'h11, 32'hCAFEF00D, SEL_WORD, 32'h112233AB};
        tbl[4]  = '{0, 1'b1, 32'h13, 32'h0,        SEL_WORD, 32'hCAFEF00D};
        tbl[5]  = '{0, 1'b0, 32'h24, 32'hFFFFFFFF, SEL_NONE, 32'hCAFEF00D};
        tbl[6]  = '{0, 1'b1, 32'h24, 32'h0,        SEL_WORD, 32'h112233AB};
        tbl[7]  = '{0, 1'b0, 32'h26, 32'h99887766, 4'b0101,  32'h112233AB};
        tbl[8]  = '{0, 1'b1, 32'h24, 32'h0,        SEL_WORD, 32'h992277AB};
        tbl[9]  = '{1, 1'b1, 32'h40, 32'h0,        SEL_WORD, 32'h600D0001};
        tbl[10] = '{1, 1'b1, 32'h44, 32'h0,        SEL_WORD, 32'h600D0002};
        tbl[11] = '{1, 1'b0, 32'h44, 32'h12345678, SEL_WORD, 32'h600D0002};
        tbl[12] = '{1, 1'b1, 32'h47, 32'h0,        SEL_WORD, 32'h12345678};

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) sram_mem[k][i] = (32'h01000000 * k) + i;
            mem_ce[k] = 1'b1; mem_we[k] = 1'b1; mem_addr[k] = '0;
            mem_data[k] = '0; mem_sel[k] = SEL_WORD;
        end
        sram_mem[0][4]  = 32'hDEADBEEF;
        sram_mem[0][9]  = 32'h11223344;
        sram_mem[1][16] = 32'h600D0001;
        sram_mem[1][17] = 32'h600D0002;

        // reset state, with a request held on the inputs
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_outputs",
                {ram_data[k], sram_wdata[k], sram_addr[k], be_n[k], ce_n[k], oe_n[k],
                 we_n[k], data_oe[k], stall[k], state[k]},
                {32'h0, 32'h0, 20'h0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'(IDLE)});
            mem_ce[k] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (posted && !tbl[i].we)
                exp_stall = 0;
            else if (posted && i > 0 && !tbl[i-1].we && tbl[i-1].k == tbl[i].k)
                exp_stall = 2 * wc[tbl[i].k] + 2;
            else
                exp_stall = wc[tbl[i].k] + 1;
            do_req(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].sel,
                   tbl[i].exp_ram, exp_stall, exp_stall == wc[tbl[i].k] + 1);
            if (i == 12 || tbl[i+1].k != tbl[i].k) begin
                @(negedge clk);
                mem_ce[tbl[i].k] = 1'b0;
            end
        end

        // request withdrawn mid-access: the cycle still runs to DONE
        @(negedge clk);
        mem_ce[1] = 1'b1; mem_we[1] = 1'b1; mem_addr[1] = 32'h40; mem_sel[1] = SEL_WORD;
        exp_q.push_back(32'h600D0001);
        @(negedge clk);
        mem_ce[1] = 1'b0;
        #1;
        chk("drop_stall", {stall[1], state[1]}, {1'b0, 2'(ACCESS)});
        n = 0;
        while (state[1] != 2'(DONE) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drop_reaches_done", state[1], 2'(DONE));
        chk("drop_ram_data", ram_data[1], exp_q.pop_front());
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            if (state[1] != 2'(IDLE) || ce_n[1] !== 1'b1) ok = 1'b0;
        end
        chk("drop_no_second_access", ok, 1'b1);

        // asynchronous reset in the middle of a store
        rnd = $urandom;
        @(negedge clk);
        mem_ce[1] = 1'b1; mem_we[1] = 1'b0; mem_addr[1] = 32'h80 + 32'($urandom_range(0, 3) * 4);
        mem_data[1] = rnd; mem_sel[1] = SEL_WORD;
        @(negedge clk);
        #2;
        chk("store_active", {we_n[1], ce_n[1], data_oe[1]}, 3'b001);
        rst = 1'b0;
        #1;
        chk("reset_mid_store", {we_n[1], ce_n[1], data_oe[1], stall[1], state[1]},
            {1'b1, 1'b1, 1'b0, 1'b0, 2'(IDLE)});
        mem_ce[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("after_reset_idle", {state[1], ce_n[1]}, {2'(IDLE), 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsram_ctrl.md
Name: dsram_ctrl

Overview:
- Data-SRAM responder on the far side of the MEM stage's memory request interface (ce/addr/data/we/sel in, read word out).
- Converts each single-cycle request into a multi-cycle asynchronous-SRAM access and holds the pipeline with stall_o until the access completes.
- Sits between the MEM stage and the external data SRAM pins; the top level owns the data tristate.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- WAIT_CYCLES, 1, number of SRAM access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- mem_ce_i  in  1  request valid.
- mem_we_i  in  1  active-low write enable: 0 = store, 1 = load.
- mem_addr_i  in  32  byte address.
- mem_data_i  in  32  store data.
- mem_sel_i  in  4  active-low byte enables: 1110 = byte 0 only, 0000 = full word.
- ram_data_o  out  32  load data returned to the MEM stage.
- stall_o  out  1  pipeline hold request.
- sram_addr_o  out  ADDR_W  SRAM word address.
- sram_wdata_o  out  32  SRAM write data.
- sram_data_oe_o  out  1  tristate drive enable for the top level.
- sram_rdata_i  in  32  SRAM read data.
- sram_ce_n_o  out  1  SRAM chip enable, active-low.
- sram_oe_n_o  out  1  SRAM output enable, active-low.
- sram_we_n_o  out  1  SRAM write enable, active-low.
- sram_be_n_o  out  4  SRAM byte enables, active-low.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-access):
  - state=IDLE.
  - ram_data_o=0, sram_addr_o=0, sram_wdata_o=0.
  - sram_data_oe_o=0, sram_ce_n_o=1, sram_oe_n_o=1, sram_we_n_o=1, sram_be_n_o=1111.
  - wait counter cleared; stall_o=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_ce_i=1, register the request and go to ACCESS; counter loads WAIT_CYCLES-1.
  - Registered fields: sram_addr_o=mem_addr_i[ADDR_W+1:2], sram_be_n_o=mem_sel_i, sram_wdata_o=mem_data_i, direction=mem_we_i.
  - Address bits [1:0] are ignored.
- ACCESS:
  - sram_ce_n_o=0.
  - Load: sram_oe_n_o=0, sram_we_n_o=1, sram_data_oe_o=0.
  - Store: sram_oe_n_o=1, sram_we_n_o=0, sram_data_oe_o=1.
  - Counter decrements each cycle; when it is 0, go to DONE.
  - Load: ram_data_o captures sram_rdata_i on that last-cycle edge. The full 32-bit word is returned; byte extraction is the MEM stage's job.
- DONE:
  - All SRAM strobes inactive (ce_n/oe_n/we_n=1, data_oe=0).
  - ram_data_o valid and held; go to IDLE next cycle.
- ram_data_o holds its value until the next load completes; stores do not change it.
- stall_o (combinational) = mem_ce_i AND (state != DONE).
  - A request stalls for exactly WAIT_CYCLES+1 cycles, then sees one stall-free cycle (DONE) in which the pipeline advances.
- Back-to-back requests: after DONE→IDLE, a new mem_ce_i=1 starts the next access. Throughput is one request per WAIT_CYCLES+2 cycles.
- mem_ce_i dropping mid-access: the SRAM cycle is not aborted; it completes through DONE. stall_o follows mem_ce_i low. The result is still captured and the FSM returns to IDLE normally.
- Request inputs are ignored outside IDLE.
- mem_sel_i=1111 with mem_ce_i=1: the access runs with no byte enabled; it is legal and harmless.

Optional Feature:
- DSRAM_POSTED_WRITE_EN defined:
  - A store presented in IDLE is registered and acknowledged in the same cycle: stall_o=0 for that store.
  - The FSM then performs the write in the background.
  - Any request arriving while the posted write is in ACCESS/DONE stalls until the FSM returns to IDLE, then proceeds normally.
  - No forwarding: a load to the same word always reads SRAM after the write completes.
- DSRAM_POSTED_WRITE_EN undefined: stores stall exactly like loads.

Decomposition:
- Package dsram_pkg:
  - state encoding constants (IDLE/ACCESS/DONE);
  - SEL_NONE=4'b1111 and SEL_WORD=4'b0000;
  - the reset value constants for the SRAM strobes.
- Optional sub-module dsram_wait_cnt: a loadable down-counter with a zero flag, width sized from WAIT_CYCLES. The FSM and pin drive stay in dsram_ctrl.

Test Plan:
- Load, WAIT_CYCLES=1: sram_rdata_i=0xDEADBEEF, mem_addr_i=0x00000010, mem_we_i=1 → sram_addr_o=0x00004, oe_n low for 1 cycle, stall_o high 2 cycles, ram_data_o=0xDEADBEEF in DONE.
- Byte store: mem_we_i=0, mem_sel_i=1110, mem_data_i=0x000000AB, addr 0x24 → sram_be_n_o=1110, sram_we_n_o low, sram_data_oe_o=1, sram_wdata_o=0x000000AB; ram_data_o unchanged.
- WAIT_CYCLES=3, two back-to-back loads → stall high 4 cycles each, one low cycle between them, each ram_data_o matches its own address's data.
- rst asserted during ACCESS of a store → sram_we_n_o=1, sram_ce_n_o=1, stall_o=0 immediately; after release, FSM in IDLE.
- mem_ce_i drops during ACCESS → stall_o=0 at once; access still ends with DONE, then IDLE; no spurious second access.
- DSRAM_POSTED_WRITE_EN: store then load on consecutive cycles → store sees stall_o=0; load stalls until the store reaches DONE, then reads the newly written value.
